// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg
// Shared definitions for the mux scan sequencer: scan FSM states, default
// word/select widths and the select stepping helper.
package mux_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SEL_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Next bit position in scan order. Callers never step past the end of the
  // requested range, so wrap-around is never exercised.
  function automatic logic [SEL_W_DEF-1:0] next_sel(
    input logic [SEL_W_DEF-1:0] sel,
    input int                   msb_first
  );
    return (msb_first != 0) ? sel - 1'b1 : sel + 1'b1;
  endfunction

endpackage

// File: rtl/mux_16cross1.sv
// mux_16cross1
// Purely combinational 16:1 bit-select multiplexer.
// Ports:
//   data  in  16  data inputs
//   sel   in  4   bit select
//   y     out 1   data[sel]
module mux_16cross1 (
  input  logic [15:0] data,
  input  logic [3:0]  sel,
  output logic        y
);

  assign y = data[sel];

endmodule

// File: rtl/ser_out_reg.sv
// ser_out_reg
// One-entry valid/ready output register for the serial stream.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   capture   in  register cap_bit/cap_last this edge (only asserted when take)
//   cap_bit   in  bit to register
//   cap_last  in  last-bit marker to register
//   ser_ready in  downstream accepts the held bit
//   take      out register can accept a new bit this edge
//   ser_valid, ser_bit, ser_last  out  registered stream
module ser_out_reg (
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  logic cap_bit,
  input  logic cap_last,
  input  logic ser_ready,
  output logic take,
  output logic ser_valid,
  output logic ser_bit,
  output logic ser_last
);

  // Empty, or the held bit leaves on this same edge.
  assign take = !ser_valid || ser_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      ser_last  <= 1'b0;
    end else if (capture) begin
      ser_valid <= 1'b1;
      ser_bit   <= cap_bit;
      ser_last  <= cap_last;
    end else if (ser_valid && ser_ready) begin
      ser_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Loads a word onto an external bit-select mux, walks the select through the
// requested bit positions and captures the mux output into a valid/ready
// serial stream with a last marker.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_valid/ready/data/len  word load port (len = bits to send - 1)
//   mux_data, mux_sel        registered word and select to the mux
//   mux_y                    mux output
//   ser_valid/ready/bit/last serial output stream
//   busy                     scan in progress
module mux_scan_sequencer
  import mux_seq_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SEL_W     = SEL_W_DEF,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [SEL_W-1:0] load_len,
  output logic [WIDTH-1:0] mux_data,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_y,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_START = (MSB_FIRST != 0) ? SEL_W'(WIDTH - 1) : '0;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] remaining, remaining_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             take;
  logic             capture;
  logic             cap_last;

  assign load_ready = (state == IDLE) && !rst;
  assign busy       = (state == SCAN);
  assign cap_last   = (remaining == '0);

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    sel_nxt       = mux_sel;
    data_nxt      = mux_data;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          data_nxt      = load_data;
          remaining_nxt = load_len;
          sel_nxt       = SEL_START;
          state_nxt     = SCAN;
        end
      end
      SCAN: begin
        if (take) begin
          capture = 1'b1;
          if (cap_last) begin
            // Select and data hold so the last bit stays observable on the mux.
            state_nxt = IDLE;
          end else begin
            remaining_nxt = remaining - 1'b1;
            sel_nxt       = SEL_W'(next_sel(mux_sel, MSB_FIRST));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      mux_sel   <= '0;
      mux_data  <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      mux_sel   <= sel_nxt;
      mux_data  <= data_nxt;
    end
  end

  ser_out_reg u_ser_out_reg (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .cap_bit   (mux_y),
    .cap_last  (cap_last),
    .ser_ready (ser_ready),
    .take      (take),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .ser_last  (ser_last)
  );

endmodule
